// File: rtl/tree_router_node.sv
// One level of the quadtree PE interconnect: parent port plus NUM_CHILD child ports,
// per-port input FIFOs, credit backpressure, unicast/broadcast down, round-robin merge up.
module tree_router_node #(
    parameter int FLIT_WIDTH    = 64,
    parameter int NUM_CHILD     = 4,
    parameter int FIFO_DEPTH    = 4,
    parameter int ADDR_WIDTH    = 6,
    parameter int CHILD_SEL_LSB = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            p_in_valid,
    input  logic [FLIT_WIDTH-1:0]           p_in_data,
    output logic                            p_out_valid,
    output logic [FLIT_WIDTH-1:0]           p_out_data,
    input  logic                            p_downstream_credit,
    output logic                            p_upstream_credit,
    input  logic [NUM_CHILD-1:0]            c_in_valid,
    input  logic [NUM_CHILD*FLIT_WIDTH-1:0] c_in_data,
    output logic [NUM_CHILD-1:0]            c_out_valid,
    output logic [NUM_CHILD*FLIT_WIDTH-1:0] c_out_data,
    input  logic [NUM_CHILD-1:0]            c_downstream_credit,
    output logic [NUM_CHILD-1:0]            c_upstream_credit,
    output logic                            err_overflow,
    output logic                            err_route,
    output logic                            idle
);

    localparam int CW = $clog2(NUM_CHILD);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] CRED_MAX = (PW+1)'(FIFO_DEPTH);
    localparam logic [PW:0] ONE      = (PW+1)'(1);
    localparam int TGT_LSB = FLIT_WIDTH - 2 - ADDR_WIDTH + CHILD_SEL_LSB;

    typedef enum logic [1:0] {
        RT_UNICAST = 2'b00,
        RT_BCAST   = 2'b01,
        RT_UP      = 2'b10,
        RT_RSVD    = 2'b11
    } route_t;

    logic [FLIT_WIDTH-1:0] p_mem [FIFO_DEPTH];
    logic [FLIT_WIDTH-1:0] c_mem [NUM_CHILD][FIFO_DEPTH];
    logic [PW:0]           p_wr, p_rd;
    logic [PW:0]           c_wr [NUM_CHILD];
    logic [PW:0]           c_rd [NUM_CHILD];
    logic [PW:0]           p_credit;
    logic [PW:0]           c_credit [NUM_CHILD];
    logic [CW-1:0]         last_grant;

    logic                  p_empty, p_full, p_at_max;
    logic [NUM_CHILD-1:0]  c_empty, c_full, c_has_credit, c_at_max;
    logic [FLIT_WIDTH-1:0] p_head, up_head;
    route_t                route;
    logic [CW-1:0]         tgt;
    logic                  p_pop, rsvd_pop;
    logic [NUM_CHILD-1:0]  c_send, c_pop;
    logic [CW-1:0]         rr_idx, up_sel;
    logic                  up_found, up_go;
    logic                  ovf_evt, route_evt;

    always_comb begin
        p_empty      = (p_wr == p_rd);
        p_full       = (p_wr[PW] != p_rd[PW]) && (p_wr[PW-1:0] == p_rd[PW-1:0]);
        p_at_max     = (p_credit == CRED_MAX);
        c_empty      = '0;
        c_full       = '0;
        c_has_credit = '0;
        c_at_max     = '0;
        for (int unsigned i = 0; i < NUM_CHILD; i++) begin
            c_empty[i]      = (c_wr[i] == c_rd[i]);
            c_full[i]       = (c_wr[i][PW] != c_rd[i][PW]) && (c_wr[i][PW-1:0] == c_rd[i][PW-1:0]);
            c_has_credit[i] = (c_credit[i] != '0);
            c_at_max[i]     = (c_credit[i] == CRED_MAX);
        end
    end

    assign p_head = p_mem[p_rd[PW-1:0]];
    assign route  = route_t'(p_head[FLIT_WIDTH-1 -: 2]);
    assign tgt    = p_head[TGT_LSB +: CW];

    // Broadcast and upward heads wait until every child can accept; never a partial send.
    always_comb begin
        p_pop    = 1'b0;
        rsvd_pop = 1'b0;
        c_send   = '0;
        if (!p_empty) begin
            unique case (route)
                RT_UNICAST: begin
                    if (c_has_credit[tgt]) begin
                        p_pop       = 1'b1;
                        c_send[tgt] = 1'b1;
                    end
                end
                RT_BCAST, RT_UP: begin
                    if (&c_has_credit) begin
                        p_pop  = 1'b1;
                        c_send = '1;
                    end
                end
                RT_RSVD: begin
                    p_pop    = 1'b1;
                    rsvd_pop = 1'b1;
                end
            endcase
        end
    end

    // Round-robin search starts one past the last grant; off == NUM_CHILD wraps to last_grant.
    always_comb begin
        rr_idx   = '0;
        up_found = 1'b0;
        up_sel   = '0;
        for (int unsigned off = 1; off <= NUM_CHILD; off++) begin
            rr_idx = last_grant + CW'(off);
            if (!up_found && !c_empty[rr_idx]) begin
                up_found = 1'b1;
                up_sel   = rr_idx;
            end
        end
        up_go = up_found && (p_credit != '0);
        c_pop = '0;
        if (up_go) c_pop[up_sel] = 1'b1;
    end

    assign up_head = c_mem[up_sel][c_rd[up_sel][PW-1:0]];

    assign ovf_evt   = (p_in_valid && p_full) || (|(c_in_valid & c_full));
    assign route_evt = rsvd_pop
                    || (p_downstream_credit && !up_go && p_at_max)
                    || (|(c_downstream_credit & ~c_send & c_at_max));

    always_ff @(posedge clk) begin
        if (p_in_valid && !p_full) p_mem[p_wr[PW-1:0]] <= p_in_data;
        for (int unsigned i = 0; i < NUM_CHILD; i++) begin
            if (c_in_valid[i] && !c_full[i])
                c_mem[i][c_wr[i][PW-1:0]] <= c_in_data[i*FLIT_WIDTH +: FLIT_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_wr              <= '0;
            p_rd              <= '0;
            p_credit          <= CRED_MAX;
            last_grant        <= '1;
            for (int unsigned i = 0; i < NUM_CHILD; i++) begin
                c_wr[i]     <= '0;
                c_rd[i]     <= '0;
                c_credit[i] <= CRED_MAX;
            end
            p_out_valid       <= 1'b0;
            p_out_data        <= '0;
            p_upstream_credit <= 1'b0;
            c_out_valid       <= '0;
            c_out_data        <= '0;
            c_upstream_credit <= '0;
            err_overflow      <= 1'b0;
            err_route         <= 1'b0;
        end else begin
            if (p_in_valid && !p_full) p_wr <= p_wr + ONE;
            if (p_pop) p_rd <= p_rd + ONE;
            case ({up_go, p_downstream_credit})
                2'b10:   p_credit <= p_credit - ONE;
                2'b01:   if (!p_at_max) p_credit <= p_credit + ONE;
                default: ;
            endcase
            for (int unsigned i = 0; i < NUM_CHILD; i++) begin
                if (c_in_valid[i] && !c_full[i]) c_wr[i] <= c_wr[i] + ONE;
                if (c_pop[i]) c_rd[i] <= c_rd[i] + ONE;
                case ({c_send[i], c_downstream_credit[i]})
                    2'b10:   c_credit[i] <= c_credit[i] - ONE;
                    2'b01:   if (!c_at_max[i]) c_credit[i] <= c_credit[i] + ONE;
                    default: ;
                endcase
                if (c_send[i]) c_out_data[i*FLIT_WIDTH +: FLIT_WIDTH] <= p_head;
            end
            if (up_go) begin
                last_grant <= up_sel;
                p_out_data <= up_head;
            end
            p_out_valid       <= up_go;
            c_out_valid       <= c_send;
            p_upstream_credit <= p_pop;
            c_upstream_credit <= c_pop;
            err_overflow      <= err_overflow | ovf_evt;
            err_route         <= err_route | route_evt;
        end
    end

    always_comb begin
        idle = p_empty && (&c_empty) && p_at_max && (&c_at_max)
            && !p_out_valid && (c_out_valid == '0);
    end

endmodule

// File: tb/tb_tree_router_node.sv
// Directed self-checking bench for tree_router_node (4 children, depth-4 FIFOs).
module tb_tree_router_node;

    localparam int FW = 64;
    localparam int NC = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              p_in_valid;
    logic [FW-1:0]     p_in_data;
    logic              p_out_valid;
    logic [FW-1:0]     p_out_data;
    logic              p_downstream_credit;
    logic              p_upstream_credit;
    logic [NC-1:0]     c_in_valid;
    logic [NC*FW-1:0]  c_in_data;
    logic [NC-1:0]     c_out_valid;
    logic [NC*FW-1:0]  c_out_data;
    logic [NC-1:0]     c_downstream_credit;
    logic [NC-1:0]     c_upstream_credit;
    logic              err_overflow;
    logic              err_route;
    logic              idle;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tree_router_node #(
        .FLIT_WIDTH(FW),
        .NUM_CHILD(NC),
        .FIFO_DEPTH(4),
        .ADDR_WIDTH(6),
        .CHILD_SEL_LSB(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .p_in_valid(p_in_valid),
        .p_in_data(p_in_data),
        .p_out_valid(p_out_valid),
        .p_out_data(p_out_data),
        .p_downstream_credit(p_downstream_credit),
        .p_upstream_credit(p_upstream_credit),
        .c_in_valid(c_in_valid),
        .c_in_data(c_in_data),
        .c_out_valid(c_out_valid),
        .c_out_data(c_out_data),
        .c_downstream_credit(c_downstream_credit),
        .c_upstream_credit(c_upstream_credit),
        .err_overflow(err_overflow),
        .err_route(err_route),
        .idle(idle)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        p_in_valid          = 1'b0;
        p_in_data           = '0;
        p_downstream_credit = 1'b0;
        c_in_valid          = '0;
        c_in_data           = '0;
        c_downstream_credit = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    function automatic logic [FW-1:0] lane(input int i);
        return c_out_data[i*FW +: FW];
    endfunction

    function automatic logic [FW-1:0] cflit(input int i, input int j);
        return {2'(i), 46'h0, 8'(i), 8'(j)};
    endfunction

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if ({p_out_valid, c_out_valid, p_upstream_credit, c_upstream_credit} !== 10'b0) begin
            errors++;
            $display("FAIL reset_valids got %b exp 0", {p_out_valid, c_out_valid, p_upstream_credit, c_upstream_credit});
        end
        checks++;
        if ({p_out_data, c_out_data} !== '0) begin
            errors++;
            $display("FAIL reset_data got %h exp 0", p_out_data);
        end
        checks++;
        if ({err_overflow, err_route, idle} !== 3'b001) begin
            errors++;
            $display("FAIL reset_flags got %b exp 001", {err_overflow, err_route, idle});
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (idle !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle_after got %b exp 1", idle);
        end
    endtask

    task automatic test_unicast();
        logic [FW-1:0] f;
        f = 64'h2500_1122_3344_5566;
        p_in_valid = 1'b1;
        p_in_data  = f;
        step();
        p_in_valid = 1'b0;
        checks++;
        if ({c_out_valid, p_upstream_credit} !== 5'b0) begin
            errors++;
            $display("FAIL uni_early got %b exp 00000", {c_out_valid, p_upstream_credit});
        end
        step();
        checks++;
        if (c_out_valid !== 4'b0100) begin
            errors++;
            $display("FAIL uni_valid got %b exp 0100", c_out_valid);
        end
        checks++;
        if (lane(2) !== f) begin
            errors++;
            $display("FAIL uni_data got %h exp %h", lane(2), f);
        end
        checks++;
        if (p_upstream_credit !== 1'b1) begin
            errors++;
            $display("FAIL uni_upcredit got %b exp 1", p_upstream_credit);
        end
        step();
        checks++;
        if ({c_out_valid, p_upstream_credit, idle} !== 6'b0) begin
            errors++;
            $display("FAIL uni_pulse_end got %b exp 000000", {c_out_valid, p_upstream_credit, idle});
        end
        c_downstream_credit = 4'b0100;
        step();
        c_downstream_credit = '0;
        checks++;
        if ({idle, err_route} !== 2'b10) begin
            errors++;
            $display("FAIL uni_credit_back got %b exp 10", {idle, err_route});
        end
    endtask

    task automatic test_broadcast();
        logic [FW-1:0] u1, bc, up;
        u1 = 64'h1000_0000_0000_00A0;
        bc = 64'h4000_0000_0000_0B0B;
        up = 64'h8000_0000_0000_0C0C;
        for (int j = 0; j < 4; j++) begin
            p_in_valid = 1'b1;
            p_in_data  = u1 + FW'(j);
            step();
            if (j >= 1) begin
                checks++;
                if (c_out_valid !== 4'b0010 || lane(1) !== u1 + FW'(j - 1)) begin
                    errors++;
                    $display("FAIL bc_fill got %b/%h exp 0010/%h", c_out_valid, lane(1), u1 + FW'(j - 1));
                end
            end
        end
        p_in_data = bc;
        step();
        p_in_valid = 1'b0;
        checks++;
        if (c_out_valid !== 4'b0010 || lane(1) !== u1 + FW'(3)) begin
            errors++;
            $display("FAIL bc_fill_last got %b/%h exp 0010/%h", c_out_valid, lane(1), u1 + FW'(3));
        end
        for (int s = 0; s < 5; s++) begin
            step();
            checks++;
            if (c_out_valid !== 4'b0000) begin
                errors++;
                $display("FAIL bc_blocked got %b exp 0000", c_out_valid);
            end
        end
        c_downstream_credit = 4'b0010;
        step();
        c_downstream_credit = '0;
        checks++;
        if (c_out_valid !== 4'b0000) begin
            errors++;
            $display("FAIL bc_t1 got %b exp 0000", c_out_valid);
        end
        step();
        checks++;
        if (c_out_valid !== 4'b1111) begin
            errors++;
            $display("FAIL bc_valid got %b exp 1111", c_out_valid);
        end
        for (int i = 0; i < NC; i++) begin
            checks++;
            if (lane(i) !== bc) begin
                errors++;
                $display("FAIL bc_data lane %0d got %h exp %h", i, lane(i), bc);
            end
        end
        step();
        checks++;
        if (c_out_valid !== 4'b0000) begin
            errors++;
            $display("FAIL bc_pulse_end got %b exp 0000", c_out_valid);
        end
        c_downstream_credit = 4'b1111;
        step();
        c_downstream_credit = 4'b0010;
        step();
        step();
        step();
        c_downstream_credit = '0;
        p_in_valid = 1'b1;
        p_in_data  = up;
        step();
        p_in_valid = 1'b0;
        step();
        checks++;
        if (c_out_valid !== 4'b1111 || lane(3) !== up || lane(0) !== up) begin
            errors++;
            $display("FAIL up_as_bc got %b/%h exp 1111/%h", c_out_valid, lane(3), up);
        end
        c_downstream_credit = 4'b1111;
        step();
        c_downstream_credit = '0;
        checks++;
        if ({idle, err_route} !== 2'b10) begin
            errors++;
            $display("FAIL bc_idle got %b exp 10", {idle, err_route});
        end
    endtask

    task automatic test_round_robin();
        logic          ev;
        logic [FW-1:0] ed;
        logic [NC-1:0] ecr;
        int            k;
        apply_reset();
        for (int i = 0; i < NC; i++) begin
            c_in_valid[i]          = 1'b1;
            c_in_data[i*FW +: FW]  = cflit(i, 0);
        end
        for (int t = 1; t <= 21; t++) begin
            step();
            for (int i = 0; i < NC; i++) begin
                c_in_valid[i]         = (t < 3);
                c_in_data[i*FW +: FW] = cflit(i, t);
            end
            p_downstream_credit = (t >= 10 && t <= 17);
            ev  = 1'b0;
            ed  = '0;
            ecr = '0;
            if (t >= 2 && t <= 5) begin
                k   = t - 2;
                ev  = 1'b1;
                ed  = cflit(k, 0);
                ecr = NC'(1) << k;
            end else if (t >= 12 && t <= 19) begin
                k   = t - 12;
                ev  = 1'b1;
                ed  = cflit(k % 4, 1 + k / 4);
                ecr = NC'(1) << (k % 4);
            end
            checks++;
            if (p_out_valid !== ev) begin
                errors++;
                $display("FAIL rr_valid t=%0d got %b exp %b", t, p_out_valid, ev);
            end
            if (ev) begin
                checks++;
                if (p_out_data !== ed) begin
                    errors++;
                    $display("FAIL rr_data t=%0d got %h exp %h", t, p_out_data, ed);
                end
            end
            checks++;
            if (c_upstream_credit !== ecr) begin
                errors++;
                $display("FAIL rr_upcredit t=%0d got %b exp %b", t, c_upstream_credit, ecr);
            end
        end
        p_downstream_credit = 1'b1;
        repeat (4) step();
        p_downstream_credit = 1'b0;
        checks++;
        if ({idle, err_route} !== 2'b10) begin
            errors++;
            $display("FAIL rr_idle got %b exp 10", {idle, err_route});
        end
    endtask

    task automatic test_overflow();
        logic [FW-1:0] bcb, ub;
        bcb = 64'h4000_0000_0000_0D00;
        ub  = 64'h0000_0000_0000_00B0;
        apply_reset();
        p_in_valid = 1'b1;
        p_in_data  = bcb;
        for (int t = 1; t <= 9; t++) begin
            step();
            p_in_valid = (t <= 8);
            p_in_data  = (t < 4) ? bcb + FW'(t) : ub + FW'(t - 4);
            if (t == 5) begin
                checks++;
                if (c_out_valid !== 4'b1111) begin
                    errors++;
                    $display("FAIL ovf_bc4 got %b exp 1111", c_out_valid);
                end
            end
            if (t == 6) begin
                checks++;
                if (c_out_valid !== 4'b0000) begin
                    errors++;
                    $display("FAIL ovf_nocredit got %b exp 0000", c_out_valid);
                end
            end
            if (t == 8) begin
                checks++;
                if (err_overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_before got %b exp 0", err_overflow);
                end
            end
            if (t == 9) begin
                checks++;
                if (err_overflow !== 1'b1) begin
                    errors++;
                    $display("FAIL ovf_set got %b exp 1", err_overflow);
                end
            end
        end
        repeat (5) step();
        checks++;
        if (err_overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky got %b exp 1", err_overflow);
        end
        c_downstream_credit = 4'b0001;
        for (int s = 1; s <= 9; s++) begin
            step();
            c_downstream_credit = (s < 4) ? 4'b0001 : 4'b0000;
            checks++;
            if (s >= 2 && s <= 5) begin
                if (c_out_valid !== 4'b0001 || lane(0) !== ub + FW'(s - 2) || p_upstream_credit !== 1'b1) begin
                    errors++;
                    $display("FAIL ovf_drain s=%0d got %b/%h exp 0001/%h", s, c_out_valid, lane(0), ub + FW'(s - 2));
                end
            end else if (c_out_valid !== 4'b0000) begin
                errors++;
                $display("FAIL ovf_dropped s=%0d got %b exp 0000", s, c_out_valid);
            end
        end
        c_downstream_credit = 4'b1111;
        repeat (4) step();
        c_downstream_credit = '0;
        checks++;
        if ({idle, err_route} !== 2'b10) begin
            errors++;
            $display("FAIL ovf_idle got %b exp 10", {idle, err_route});
        end
    endtask

    task automatic test_reserved();
        apply_reset();
        p_in_valid = 1'b1;
        p_in_data  = 64'hC000_0000_0000_00EE;
        step();
        p_in_valid = 1'b0;
        checks++;
        if ({p_upstream_credit, err_route} !== 2'b00) begin
            errors++;
            $display("FAIL rsvd_early got %b exp 00", {p_upstream_credit, err_route});
        end
        step();
        checks++;
        if ({p_upstream_credit, c_out_valid, err_route} !== 6'b1_0000_1) begin
            errors++;
            $display("FAIL rsvd_drop got %b exp 100001", {p_upstream_credit, c_out_valid, err_route});
        end
        step();
        checks++;
        if ({idle, err_route} !== 2'b11) begin
            errors++;
            $display("FAIL rsvd_after got %b exp 11", {idle, err_route});
        end
        apply_reset();
        checks++;
        if (err_route !== 1'b0) begin
            errors++;
            $display("FAIL rsvd_reset got %b exp 0", err_route);
        end
        c_downstream_credit = 4'b1000;
        step();
        c_downstream_credit = '0;
        checks++;
        if ({err_route, idle, err_overflow} !== 3'b110) begin
            errors++;
            $display("FAIL spurious_credit got %b exp 110", {err_route, idle, err_overflow});
        end
    endtask

    task automatic test_reset_mid();
        logic [FW-1:0] f;
        f = 64'h2500_0000_0000_0F0F;
        apply_reset();
        p_in_valid = 1'b1;
        p_in_data  = 64'h1000_0000_0000_0001;
        step();
        p_in_data  = 64'h1000_0000_0000_0002;
        step();
        checks++;
        if (c_out_valid !== 4'b0010) begin
            errors++;
            $display("FAIL mid_inflight got %b exp 0010", c_out_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({p_out_valid, c_out_valid, p_upstream_credit, c_upstream_credit, idle} !== 11'b000000_0000_1) begin
            errors++;
            $display("FAIL mid_reset got %b exp 00000000001", {p_out_valid, c_out_valid, p_upstream_credit, c_upstream_credit, idle});
        end
        checks++;
        if (c_out_data !== '0) begin
            errors++;
            $display("FAIL mid_reset_data got %h exp 0", lane(1));
        end
        clear_inputs();
        step();
        rst_n = 1'b1;
        p_in_valid = 1'b1;
        p_in_data  = f;
        step();
        p_in_valid = 1'b0;
        checks++;
        if (c_out_valid !== 4'b0000) begin
            errors++;
            $display("FAIL mid_next_early got %b exp 0000", c_out_valid);
        end
        step();
        checks++;
        if (c_out_valid !== 4'b0100 || lane(2) !== f) begin
            errors++;
            $display("FAIL mid_next got %b/%h exp 0100/%h", c_out_valid, lane(2), f);
        end
        step();
        c_downstream_credit = 4'b0100;
        step();
        c_downstream_credit = '0;
        checks++;
        if ({idle, err_route, err_overflow} !== 3'b100) begin
            errors++;
            $display("FAIL mid_idle got %b exp 100", {idle, err_route, err_overflow});
        end
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_unicast();
        test_broadcast();
        test_round_robin();
        test_overflow();
        test_reserved();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tree_router_node.md
# tree_router_node

Parametrised credit-flow router node for the quadtree broadcast network, one level of the PE interconnect. It replaces the fixed root/internal/leaf node variants with a single block: one parent port, NUM_CHILD child ports, per-port input FIFOs, credit-based backpressure, unicast/broadcast downward routing and round-robin upward merging. Instances are stacked at each tree level, with CHILD_SEL_LSB selecting the destination-index bits that level decodes.

## Interface
- FLIT_WIDTH, 64: flit width; [FLIT_WIDTH-1:FLIT_WIDTH-2] = route type, [FLIT_WIDTH-3 -: ADDR_WIDTH] = destination PE index.
- NUM_CHILD, 4: child ports, power of two, 2..8; CW = log2(NUM_CHILD).
- FIFO_DEPTH, 4: entries per input FIFO, power of two ≥2; also the initial credit count of every output.
- ADDR_WIDTH, 6: destination PE index width.
- CHILD_SEL_LSB, 4: child index = dest[CHILD_SEL_LSB +: CW].
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- p_in_valid / p_in_data  in  1 / FLIT_WIDTH  flit from parent.
- p_out_valid / p_out_data  out  1 / FLIT_WIDTH  flit to parent.
- p_downstream_credit  in  1  credit pulse from parent (one slot freed).
- p_upstream_credit  out  1  credit pulse to parent.
- c_in_valid / c_in_data  in  NUM_CHILD / NUM_CHILD*FLIT_WIDTH  flits from children, child i at [i*FLIT_WIDTH +: FLIT_WIDTH].
- c_out_valid / c_out_data  out  NUM_CHILD / NUM_CHILD*FLIT_WIDTH  flits to children.
- c_downstream_credit  in  NUM_CHILD  credit pulses from children.
- c_upstream_credit  out  NUM_CHILD  credit pulses to children.
- err_overflow  out  1  sticky: a flit arrived at a full FIFO.
- err_route  out  1  sticky: a reserved route type was popped, or a credit counter exceeded FIFO_DEPTH.
- idle  out  1  all FIFOs empty, all credit counters at FIFO_DEPTH, no output valid.

## Operation
- Route types: 00 unicast, 01 broadcast, 10 upward, 11 reserved.
- Parent FIFO head, unicast:
  - Target child k = dest[CHILD_SEL_LSB +: CW].
  - Sent when credit[k] > 0.
- Parent FIFO head, broadcast:
  - Sent only when every child credit is > 0.
  - All c_out_valid assert in the same cycle with identical data.
  - All child credits decrement together.
  - No partial broadcast, ever.
- Parent FIFO head, upward: treated as a broadcast.
- Parent FIFO head, reserved: popped and dropped; err_route set; credit still returned.
- Child FIFOs: all flits go to the parent regardless of type.
  - Round-robin arbitration over non-empty child FIFOs, gated by parent credit > 0.
  - Search starts at last_grant+1 mod NUM_CHILD.
  - last_grant updates only on a grant; reset value NUM_CHILD-1, so child 0 has first priority.
- Parent and child paths are independent: a downward and an upward transfer may occur in the same cycle.
- Credit counters: one per output, width log2(FIFO_DEPTH)+1.
  - Decrement on send; increment on a downstream_credit pulse; both in one cycle leaves the count unchanged.
  - An increment beyond FIFO_DEPTH saturates and sets err_route.
- FIFO write with in_valid at full: flit dropped, err_overflow set, FIFO unchanged. A write and a pop in the same cycle at full is also an overflow; under correct credit use this cannot occur.
- Every FIFO pop produces exactly one upstream_credit pulse on that port.

## Timing
- Reset values: all out_valid 0, out_data 0, upstream credits 0, err flags 0, idle 1, FIFOs empty, credits = FIFO_DEPTH, last_grant = NUM_CHILD-1.
- Flit with in_valid in cycle N is written at the end of cycle N. It is the FIFO head in N+1. If routable, it pops at the end of N+1. out_valid is registered and high in N+2.
- upstream_credit for that slot pulses in N+2, the same cycle as out_valid.
- out_valid is a single-cycle pulse per flit; back-to-back flits give consecutive valid cycles, for a throughput of 1 flit/cycle/path.
- A credit pulse arriving in cycle N is usable for a send decision in N+1.
- Blocked head (no credit): the head stays; later flits behind it wait (in-order, no bypass).
- Reset asserted mid-transfer: all state clears immediately. In-flight flits and credits are lost; the neighbours are reset by the same rst_n.

## Test plan
- Unicast, dest=0x25, CHILD_SEL_LSB=4, in at cycle 10 -> c_out_valid[2] high at cycle 12 with identical data; p_upstream_credit pulse at 12; credit[2] 4->3.
- Broadcast with credit[1]=0 -> nothing sent until a c_downstream_credit[1] pulse at cycle T; all four c_out_valid high together at T+2; all credits decrement.
- All four children inject 3 flits each at the same cycle, parent credit 4 -> parent outputs interleave children 0,1,2,3,0,1,2,3,…. With no parent credit returns, exactly 4 flits go out, then the stall holds until credits return.
- Five parent flits with no pops (all child credits 0) -> the 5th is dropped and err_overflow=1, held until rst_n.
- Reserved-type flit -> no output; err_route=1; p_upstream_credit still pulses. A spurious downstream credit at a full counter also sets err_route.
- rst_n low for 1 cycle mid-stream -> all outputs 0 and idle=1 immediately; counters back at FIFO_DEPTH; the next flit routes normally with 2-cycle latency.
